// File: rtl/raid_write_dispatcher.sv
// Queues changed RAID stripes and writes D0, D1 and P to the disks one at a time.
// Optional skip counter: define RAID_WRITE_SKIP_CNT_EN to add the skip_cnt port and counter.
module raid_write_dispatcher #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        compare_valid,
    input  logic        equal,
    input  logic [11:0] D0_enc_in,
    input  logic [11:0] D1_enc_in,
    input  logic [11:0] P_in,
    input  logic [7:0]  address_in,
    output logic        busy,
    output logic        disk_wr_en,
    output logic [1:0]  disk_sel,
    output logic [7:0]  disk_addr,
    output logic [11:0] disk_wdata,
    input  logic        disk_wr_ack,
    output logic        write_done,
    output logic        overflow
`ifdef RAID_WRITE_SKIP_CNT_EN
    ,
    output logic [15:0] skip_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]  addr;
        logic [11:0] d0;
        logic [11:0] d1;
        logic [11:0] p;
    } req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_D0 = 3'd1,
        WR_D1 = 3'd2,
        WR_P  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    req_t           mem_q [FIFO_DEPTH];
    req_t           work_q, work_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           push_req, push, pop, full, drop;
    req_t           in_req;

    assign in_req   = '{addr: address_in, d0: D0_enc_in, d1: D1_enc_in, p: P_in};
    assign full     = (count_q == DEPTH_C);
    assign busy     = full;
    assign overflow = overflow_q;
    assign push_req = compare_valid & ~equal;
    // A full queue can still take a request when the FSM pops at the same edge.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        pop        = 1'b0;
        disk_wr_en = 1'b0;
        disk_sel   = 2'd0;
        disk_addr  = 8'd0;
        disk_wdata = 12'd0;
        write_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    work_d  = mem_q[rd_ptr_q];
                    state_d = WR_D0;
                end
            end
            WR_D0: begin
                disk_wr_en = 1'b1;
                disk_sel   = 2'd0;
                disk_addr  = work_q.addr;
                disk_wdata = work_q.d0;
                if (disk_wr_ack) state_d = WR_D1;
            end
            WR_D1: begin
                disk_wr_en = 1'b1;
                disk_sel   = 2'd1;
                disk_addr  = work_q.addr;
                disk_wdata = work_q.d1;
                if (disk_wr_ack) state_d = WR_P;
            end
            WR_P: begin
                disk_wr_en = 1'b1;
                disk_sel   = 2'd2;
                disk_addr  = work_q.addr;
                disk_wdata = work_q.p;
                if (disk_wr_ack) state_d = DONE;
            end
            DONE: begin
                write_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_req;
    end

`ifdef RAID_WRITE_SKIP_CNT_EN
    logic [15:0] skip_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= 16'd0;
        end else if (compare_valid && equal && skip_q != 16'hFFFF) begin
            skip_q <= skip_q + 16'd1;
        end
    end

    assign skip_cnt = skip_q;
`endif

endmodule

// File: tb/tb_raid_write_dispatcher.sv
// Self-checking bench for raid_write_dispatcher: vector table, directed corner sequences,
// and randomized traffic against a request-level reference model.
module tb_raid_write_dispatcher;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        compare_valid = 1'b0;
    logic        equal = 1'b0;
    logic [11:0] D0_enc_in = '0;
    logic [11:0] D1_enc_in = '0;
    logic [11:0] P_in = '0;
    logic [7:0]  address_in = '0;
    logic        disk_wr_ack = 1'b0;
    logic        busy, disk_wr_en, write_done, overflow;
    logic [1:0]  disk_sel;
    logic [7:0]  disk_addr;
    logic [11:0] disk_wdata;
`ifdef RAID_WRITE_SKIP_CNT_EN
    logic [15:0] skip_cnt;
`endif

    raid_write_dispatcher #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .compare_valid(compare_valid), .equal(equal),
        .D0_enc_in(D0_enc_in), .D1_enc_in(D1_enc_in), .P_in(P_in), .address_in(address_in),
        .busy(busy), .disk_wr_en(disk_wr_en), .disk_sel(disk_sel), .disk_addr(disk_addr),
        .disk_wdata(disk_wdata), .disk_wr_ack(disk_wr_ack), .write_done(write_done),
        .overflow(overflow)
`ifdef RAID_WRITE_SKIP_CNT_EN
        , .skip_cnt(skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input bit en, input logic [1:0] sel,
                           input logic [7:0] a, input logic [11:0] d, input bit done,
                           input bit bz, input bit ov);
        chk({nm, ".wr_en"}, 32'(disk_wr_en), 32'(en));
        chk({nm, ".sel"},   32'(disk_sel),   32'(sel));
        chk({nm, ".addr"},  32'(disk_addr),  32'(a));
        chk({nm, ".wdata"}, 32'(disk_wdata), 32'(d));
        chk({nm, ".done"},  32'(write_done), 32'(done));
        chk({nm, ".busy"},  32'(busy),       32'(bz));
        chk({nm, ".ovf"},   32'(overflow),   32'(ov));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input bit cv, input bit eq, input logic [7:0] a, input logic [11:0] d0,
                         input logic [11:0] d1, input logic [11:0] p, input bit ack);
        @(negedge clk);
        compare_valid = cv; equal = eq; address_in = a;
        D0_enc_in = d0; D1_enc_in = d1; P_in = p; disk_wr_ack = ack;
        #1;
    endtask

    task automatic idle(input bit ack);
        drive(1'b0, 1'b0, 8'h00, 12'h000, 12'h000, 12'h000, ack);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        compare_valid = 1'b0; equal = 1'b0; disk_wr_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_out("in_reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    typedef struct {
        bit cv, eq;
        logic [7:0] a;
        logic [11:0] d0, d1, p;
        bit ack;
        bit en;
        logic [1:0] sel;
        logic [7:0] oa;
        logic [11:0] od;
        bit done, bz;
    } vec_t;

    function automatic vec_t mk(bit cv, bit eq, logic [7:0] a, logic [11:0] d0, logic [11:0] d1,
                                logic [11:0] p, bit ack, bit en, logic [1:0] sel,
                                logic [7:0] oa, logic [11:0] od, bit done, bit bz);
        vec_t v;
        v.cv = cv; v.eq = eq; v.a = a; v.d0 = d0; v.d1 = d1; v.p = p; v.ack = ack;
        v.en = en; v.sel = sel; v.oa = oa; v.od = od; v.done = done; v.bz = bz;
        return v;
    endfunction

    // Reference model: requests waiting, the request in flight and which of its writes is next.
    typedef struct {
        logic [7:0] a;
        logic [11:0] d0, d1, p;
    } req_t;

    req_t        pend[$];
    req_t        cur;
    bit          active;
    int          phase;    // 0..2 = disk being written, 3 = completion pulse
    bit          m_ovf;
    int          m_skip;
    logic [21:0] exp_q[$];

    task automatic model_clear();
        pend.delete(); exp_q.delete();
        active = 0; phase = 0; m_ovf = 0; m_skip = 0;
    endtask

    task automatic model_cycle(input bit cv, input bit eq, input logic [7:0] a,
                               input logic [11:0] d0, input logic [11:0] d1,
                               input logic [11:0] p, input bit ack);
        bit          e_en, e_done, pop;
        logic [1:0]  e_sel;
        logic [7:0]  e_a;
        logic [11:0] e_d;
        req_t        r;
        drive(cv, eq, a, d0, d1, p, ack);
        e_en = 0; e_done = 0; e_sel = 0; e_a = 0; e_d = 0;
        if (active && phase < 3) begin
            e_en = 1; e_sel = 2'(phase); e_a = cur.a;
            e_d = (phase == 0) ? cur.d0 : (phase == 1) ? cur.d1 : cur.p;
        end else if (active) begin
            e_done = 1;
        end
        chk_out("rand", e_en, e_sel, e_a, e_d, e_done, pend.size() == DEPTH, m_ovf);
`ifdef RAID_WRITE_SKIP_CNT_EN
        chk("rand.skip", 32'(skip_cnt), 32'(m_skip));
`endif
        if (disk_wr_en && ack) begin
            if (exp_q.size() == 0) chk("sb.unexpected_write", 32'(1), 32'(0));
            else chk("sb.write", {10'd0, disk_sel, disk_addr, disk_wdata}, {10'd0, exp_q.pop_front()});
        end
        // Advance the model across the coming rising edge.
        pop = !active && pend.size() > 0;
        if (pop) cur = pend.pop_front();
        if (cv && !eq) begin
            if (pend.size() < DEPTH) begin
                r.a = a; r.d0 = d0; r.d1 = d1; r.p = p;
                pend.push_back(r);
                exp_q.push_back({2'd0, a, d0});
                exp_q.push_back({2'd1, a, d1});
                exp_q.push_back({2'd2, a, p});
            end else begin
                m_ovf = 1;
            end
        end
        if (cv && eq && m_skip < 16'hFFFF) m_skip++;
        if (pop) begin
            active = 1; phase = 0;
        end else if (active) begin
            if (phase == 3) active = 0;
            else if (ack) phase++;
        end
    endtask

    vec_t tbl[$];
    int   ndone;
    logic [7:0] seen[$];

    initial begin
        // Single request, a skip burst, then a request with extreme field values.
        tbl.push_back(mk(1,0,8'h2A,12'h123,12'h456,12'h575,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 1,0,8'h2A,12'h123,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 1,1,8'h2A,12'h456,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 1,2,8'h2A,12'h575,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 0,0,8'h00,12'h000,1,0));
        tbl.push_back(mk(1,1,8'h11,12'h111,12'h222,12'h333,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(1,1,8'h12,12'h444,12'h555,12'h666,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(1,1,8'h13,12'h777,12'h888,12'h999,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(1,0,8'hFF,12'hFFF,12'h000,12'hABC,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 0,0,8'h00,12'h000,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 1,0,8'hFF,12'hFFF,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 1,1,8'hFF,12'h000,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 1,2,8'hFF,12'hABC,0,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 0,0,8'h00,12'h000,1,0));
        tbl.push_back(mk(0,0,8'h00,12'h000,12'h000,12'h000,1, 0,0,8'h00,12'h000,0,0));

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].eq, tbl[i].a, tbl[i].d0, tbl[i].d1, tbl[i].p, tbl[i].ack);
            chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].sel, tbl[i].oa, tbl[i].od,
                    tbl[i].done, tbl[i].bz, 0);
        end
`ifdef RAID_WRITE_SKIP_CNT_EN
        chk("skip_cnt_after_3", 32'(skip_cnt), 32'd3);
`endif

        // Back-pressure: ack withheld for five cycles while writing D1.
        do_reset();
        drive(1, 0, 8'h33, 12'hAAA, 12'hBBB, 12'hCCC, 1);
        idle(1);
        idle(1);
        chk_out("bp.d0", 1, 0, 8'h33, 12'hAAA, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            idle(0);
            chk_out($sformatf("bp.hold%0d", k), 1, 1, 8'h33, 12'hBBB, 0, 0, 0);
        end
        idle(1);
        chk_out("bp.ack", 1, 1, 8'h33, 12'hBBB, 0, 0, 0);
        idle(1);
        chk_out("bp.p", 1, 2, 8'h33, 12'hCCC, 0, 0, 0);
        idle(1);
        chk_out("bp.done", 0, 0, 0, 0, 1, 0, 0);

        // Overflow: six pushes while disks stall; the sixth is dropped.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 8'(8'h10 + k), 12'(12'h100 + k), 12'(12'h200 + k), 12'(12'h300 + k), 0);
            if (k == 5) chk_out("ovf.full", 1, 0, 8'h10, 12'h100, 0, 1, 0);
        end
        idle(0);
        chk_out("ovf.sticky", 1, 0, 8'h10, 12'h100, 0, 1, 1);
        ndone = 0;
        seen.delete();
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (write_done) ndone++;
            if (disk_wr_en && disk_sel == 2'd0) seen.push_back(disk_addr);
        end
        chk("ovf.done_pulses", 32'(ndone), 32'd5);
        chk("ovf.write_count", 32'(seen.size()), 32'd5);
        foreach (seen[i]) chk($sformatf("ovf.order%0d", i), 32'(seen[i]), 32'(8'h10 + i));
        chk_out("ovf.drained", 0, 0, 0, 0, 0, 0, 1);

        // Reset during WR_P with two requests queued.
        do_reset();
        drive(1, 0, 8'h41, 12'h141, 12'h241, 12'h341, 0);
        drive(1, 0, 8'h42, 12'h142, 12'h242, 12'h342, 0);
        drive(1, 0, 8'h43, 12'h143, 12'h243, 12'h343, 0);
        idle(1);
        idle(1);
        idle(0);
        chk_out("rst.wr_p", 1, 2, 8'h41, 12'h341, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk_out("rst.async", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idle(1);
            chk_out($sformatf("rst.quiet%0d", k), 0, 0, 0, 0, 0, 0, 0);
        end
        // A push on the very first edge after release must be taken.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compare_valid = 1; equal = 0; address_in = 8'h5C;
        D0_enc_in = 12'h5C0; D1_enc_in = 12'h5C1; P_in = 12'h5C2; disk_wr_ack = 1;
        idle(1);
        chk_out("rst.first_pop", 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk_out("rst.first_write", 1, 0, 8'h5C, 12'h5C0, 0, 0, 0);

        // Randomized traffic against the reference model, then a drain.
        do_reset();
        model_clear();
        for (int k = 0; k < 600; k++) begin
            model_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 3) == 0,
                        8'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                        $urandom_range(0, 99) < 55);
        end
        for (int k = 0; k < 80; k++) model_cycle(0, 0, 8'h00, 12'h000, 12'h000, 12'h000, 1);
        chk("sb.drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/raid_write_dispatcher.md
RAID_WRITE_DISPATCHER -- requirements
Module: raid_write_dispatcher

Interface
REQ-001 SHALL provide parameter: FIFO_DEPTH, default 4, request-queue depth (power of 2, 2..16).
REQ-002 SHALL provide ports, one per line, as listed below.
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- compare_valid  input  1  compare result valid this cycle.
- equal  input  1  new encoded block equals stored block.
- D0_enc_in  input  12  encoded data block for disk 0.
- D1_enc_in  input  12  encoded data block for disk 1.
- P_in  input  12  parity block.
- address_in  input  8  block address.
- busy  output  1  queue full; upstream must hold off.
- disk_wr_en  output  1  write request to the selected disk.
- disk_sel  output  2  target disk: 0=D0, 1=D1, 2=P (3 never driven).
- disk_addr  output  8  write address.
- disk_wdata  output  12  write data.
- disk_wr_ack  input  1  disk accepted the current write.
- write_done  output  1  one-cycle pulse: all three writes of a request finished.
- overflow  output  1  sticky flag: a request was dropped.
- skip_cnt  output  16  count of writes skipped because equal=1 (present only with the macro in REQ-019).

Function
REQ-003 SHALL push {address_in, D0_enc_in, D1_enc_in, P_in} into the FIFO at the clock edge where compare_valid=1, equal=0, and the FIFO is not full, or is full with a pop at the same edge.
REQ-004 SHALL NOT push when compare_valid=1 and equal=1: the block is unchanged and no disk write is needed.
REQ-005 SHALL drop the request and set overflow=1 when compare_valid=1, equal=0, the FIFO is full and there is no simultaneous pop; overflow stays set until reset.
REQ-006 SHALL drive busy=1 exactly when the FIFO occupancy equals FIFO_DEPTH; busy is combinational from occupancy.
REQ-007 SHALL implement FSM states IDLE, WR_D0, WR_D1, WR_P, DONE.
REQ-008 IDLE: if occupancy != 0, pop the head into a working register at that edge and go to WR_D0; otherwise stay in IDLE.
REQ-009 WR_D0/WR_D1/WR_P: disk_wr_en=1; disk_sel=0/1/2; disk_addr=working address; disk_wdata=working D0/D1/P. All held stable until disk_wr_ack=1 is sampled, then advance WR_D0->WR_D1->WR_P->DONE.
REQ-010 DONE: write_done=1 for exactly one cycle; next state IDLE.
REQ-011 In IDLE and DONE: disk_wr_en=0, disk_sel=0, disk_addr=0, disk_wdata=0.
REQ-012 disk_wr_ack SHALL be ignored in IDLE and DONE.
REQ-013 Latency, empty FIFO in IDLE: push at edge N -> pop at edge N+1 -> disk_wr_en=1 with disk_sel=0 in cycle N+2. With a single-cycle ack per disk, write_done is high in cycle N+5.
REQ-014 Requests SHALL be written in strict FIFO order; occupancy pointers wrap modulo FIFO_DEPTH.
REQ-015 A push arriving while the FSM is mid-request SHALL be queued and SHALL NOT disturb the working register.

Reset
REQ-016 Asserting reset at any time, including mid-write, SHALL immediately force: state IDLE, FIFO empty, working register 0, and all outputs 0 (busy, disk_wr_en, disk_sel, disk_addr, disk_wdata, write_done, overflow, skip_cnt).
REQ-017 A write interrupted by reset SHALL NOT be resumed after reset is released.
REQ-018 The first push SHALL be accepted at the first rising clk edge after reset deasserts.

Configuration
REQ-019 With macro RAID_WRITE_SKIP_CNT_EN defined, the skip_cnt port and counter SHALL exist:
- increments by 1 at each edge where compare_valid=1 and equal=1;
- saturates at 16'hFFFF;
- resets to 0.
REQ-020 Without RAID_WRITE_SKIP_CNT_EN, the skip_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-021 Single request: compare_valid=1, equal=0, address_in=8'h2A, D0=12'h123, D1=12'h456, P=12'h575, disk_wr_ack tied 1 -> writes (sel0,2A,123), (sel1,2A,456), (sel2,2A,575) in cycles N+2..N+4; write_done=1 in cycle N+5.
REQ-022 Skip: compare_valid=1, equal=1 three times -> no disk_wr_en; skip_cnt=3 (macro defined).
REQ-023 Back-pressure: ack held 0 for 5 cycles in WR_D1 -> disk_wr_en=1, disk_sel=1 and data held stable for all 5 cycles; advances to WR_P one cycle after ack=1.
REQ-024 Overflow: ack held 0, 6 pushes with FIFO_DEPTH=4 -> first is popped, next 4 fill the queue (busy=1), 6th dropped (overflow=1); after acks, exactly 5 write_done pulses in push order.
REQ-025 Reset mid-write: assert reset during WR_P with 2 entries queued -> all outputs 0; after release, no disk_wr_en until a new push.
